anita3_surf_cmd_receiver: RTL and testbench
===========================================

// Module: ANITA3_surf_cmd_receiver
// PURPOSE
//  SURF-side decoder for the serial CMD line that TRIGGER_INTERFACE drives, one line per SURF.
//  Deserialises each frame and checks parity and stop bit. Then presents the decoded command:
//   type, buffer and 32-bit event ID.
//  Tracks which of the 4 hold buffers await readout.
//  Feeds the SURF digitizer/readout logic. Single clock domain, clk33_i.
// PARAMETERS
//  NUM_DATA_BITS  32  payload width (event ID)
//  NUM_BUFFERS    4   hold buffers; buffer field is log2(NUM_BUFFERS)=2 bits
//  ERR_CNT_BITS   8   width of saturating error counter
// PORTS
//  clk33_i            in   1   33 MHz clock; CMD_i is one bit per clk33_i cycle
//  rst_i              in   1   synchronous, active-high reset
//  CMD_i              in   1   serial command line from TURF (asynchronous to receiver)
//  buf_done_i         in   4   one-hot pulses: readout of buffer n finished
//  cmd_valid_o        out  1   1-cycle pulse: good frame decoded
//  cmd_type_o         out  2   00 digitize, 01 clear buffer, 10 reserved, 11 clear all
//  cmd_buffer_o       out  2   buffer field of last good frame
//  cmd_data_o         out  32  payload (event ID) of last good frame
//  digitize_o         out  1   1-cycle pulse, = cmd_valid_o & type 00
//  buffer_pending_o   out  4   buffer n digitized, not yet done/cleared
//  parity_err_o       out  1   1-cycle pulse on parity failure
//  frame_err_o        out  1   1-cycle pulse on bad stop bit
//  overrun_o          out  1   1-cycle pulse: digitize to an already pending buffer
//  err_count_o        out  8   saturating count of parity+frame+overrun events
// BEHAVIOUR
//  Frame, 39 bits, MSB first:
//   - b0 start=1
//   - b1-2 type
//   - b3-4 buffer
//   - b5-36 data
//   - b37 parity: even over b1..b37, i.e. XOR of b1..b37 = 0
//   - b38 stop=0
//  Line idles low.
//  CMD_i passes a 2-FF synchroniser. The FSM samples the synchroniser output (cmd_s).
//  FSM states:
//   - HUNT: wait for cmd_s=0, then go to IDLE.
//   - IDLE: cmd_s=1 is the start bit; go to SHIFT with bit count 0.
//   - SHIFT: shift 36 bits (type, buffer, data), then go to PARITY.
//   - PARITY: latch the parity bit, then go to STOP.
//   - STOP: see stop-bit rules below.
//  Stop bit 0 with good parity:
//   - Next cycle: cmd_valid_o=1. Type/buffer/data outputs update in that same cycle.
//   - FSM goes to IDLE.
//   - A new start bit is accepted on the cycle right after the stop bit (back-to-back frames).
//  Stop bit 0 with bad parity:
//   - parity_err_o pulses; no valid; outputs hold old values; FSM goes to IDLE.
//  Stop bit 1:
//   - frame_err_o pulses regardless of parity; no valid.
//   - FSM goes to HUNT; no resync on a high line.
//  Latency: stop bit on CMD_i in cycle N -> cmd_valid_o high in cycle N+3.
//  Pending mask update on a valid frame:
//   - type 00: set bit[buf]. If already set, pulse overrun_o; bit stays set.
//   - type 01: clear bit[buf].
//   - type 11: clear all bits.
//   - type 10: mask unchanged; cmd_valid_o still pulses.
//  buf_done_i[n] clears bit n.
//  Same cycle as a digitize to buffer n: done applies first, so no overrun and the bit ends set.
//  err_count_o:
//   - +1 per error pulse; saturates at 255.
//   - Simultaneous overrun and other errors cannot occur: overrun needs a good frame.
//  Reset, including mid-frame:
//   - All outputs 0; pending mask 0; counter 0; synchroniser 0.
//   - Bit counter 0; FSM to HUNT.
//   - A partial frame is discarded with no error flagged.
// STRUCTURE
//  Shared include ANITA3_cmd_defs.vh holds:
//   - frame length 39
//   - type codes CMD_DIGITIZE / CMD_CLEAR / CMD_RSVD / CMD_CLEAR_ALL
//   - field offsets
//  The TURF event generator also uses this include.
//  Sub-module ANITA3_cmd_deser: synchroniser, FSM and shift register.
//  Its outputs: frame strobe, raw fields, parity_ok, stop_ok.
//  The top level holds the pending mask, error pulses and counter.
// TESTING
//  1. Digitize, buffer 2, ID 0x12345678, good parity ->
//     cmd_valid_o and digitize_o pulse at N+3, cmd_data_o=0x12345678, buffer_pending_o=4'b0100.
//  2. Same frame with b37 flipped -> parity_err_o pulse, no valid, pending unchanged,
//     err_count_o=1.
//  3. Stop bit forced 1, line held high 10 cycles then low, then a good frame ->
//     frame_err_o pulse; no decode while high; good frame decodes normally.
//  4. Digitize buffer 1 twice, then buf_done_i=4'b0010 coincident with a third digitize to buffer 1 ->
//     overrun_o on the 2nd frame only; pending bit1 remains 1 at the end.
//  5. Two good frames back-to-back, no idle gap ->
//     two cmd_valid_o pulses exactly 39 cycles apart; then type 11 -> pending=0.
//  6. rst_i asserted at bit 20 of a frame, released while line still mid-frame ->
//     all outputs 0, no error or valid from the remnant; next clean frame decodes.

Source files
------------

// File: rtl/anita3_surf_cmd_receiver_pkg.sv
// Shared definitions for the SURF command line: frame layout, command codes,
// decoded-field payload and deserialiser state encoding.
package anita3_surf_cmd_receiver_pkg;

  localparam int unsigned NUM_DATA_BITS = 32;
  localparam int unsigned NUM_BUFFERS   = 4;
  localparam int unsigned BUF_BITS      = 2;
  localparam int unsigned TYPE_BITS     = 2;
  localparam int unsigned ERR_CNT_BITS  = 8;

  // Frame layout, bit 0 is the first bit on the wire
  localparam int unsigned FRAME_LEN     = 39;
  localparam int unsigned OFS_START     = 0;
  localparam int unsigned OFS_TYPE      = 1;
  localparam int unsigned OFS_BUF       = 3;
  localparam int unsigned OFS_DATA      = 5;
  localparam int unsigned OFS_PARITY    = 37;
  localparam int unsigned OFS_STOP      = 38;

  localparam int unsigned PAYLOAD_BITS  = OFS_PARITY - OFS_TYPE;
  localparam int unsigned BIT_CNT_BITS  = 6;
  localparam int unsigned LAST_SHIFT    = PAYLOAD_BITS - 1;

  typedef enum logic [TYPE_BITS-1:0] {
    CMD_DIGITIZE  = 2'b00,
    CMD_CLEAR     = 2'b01,
    CMD_RSVD      = 2'b10,
    CMD_CLEAR_ALL = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } deser_state_e;

  // Field order matches shift order, so the shift register maps straight onto it
  typedef struct packed {
    cmd_type_e                  cmd_type;
    logic [BUF_BITS-1:0]        buffer;
    logic [NUM_DATA_BITS-1:0]   data;
  } cmd_fields_t;

  function automatic logic [ERR_CNT_BITS-1:0] sat_inc(input logic [ERR_CNT_BITS-1:0] v);
    return (&v) ? v : v + ERR_CNT_BITS'(1);
  endfunction

endpackage

// File: rtl/anita3_surf_cmd_receiver_deser.sv
// CMD line deserialiser: 2-FF synchroniser, framing FSM and payload shift register.
// Frame strobe and status are combinational during the stop-bit cycle.
module anita3_surf_cmd_receiver_deser
  import anita3_surf_cmd_receiver_pkg::*;
(
  input  logic        clk33_i,
  input  logic        rst_i,
  input  logic        cmd_i,
  output logic        frame_done_c,
  output logic        parity_ok_c,
  output logic        stop_ok_c,
  output cmd_fields_t fields_o
);

  logic [1:0]              sync_q, sync_d;
  logic                    cmd_s;
  deser_state_e            state_q, state_d;
  logic [BIT_CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    par_q, par_d;

  assign cmd_s = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], cmd_i};
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
    end
  end

  // A stuck-high line after a framing error must drop low before we re-arm
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT:   if (!cmd_s) state_d = ST_IDLE;
      ST_IDLE:   if (cmd_s) state_d = ST_SHIFT;
      ST_SHIFT:  if (bit_cnt_q == BIT_CNT_BITS'(LAST_SHIFT)) state_d = ST_PARITY;
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = cmd_s ? ST_HUNT : ST_IDLE;
      default:   state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_s) bit_cnt_d = '0;
      end
      ST_SHIFT: begin
        shift_d   = {shift_q[PAYLOAD_BITS-2:0], cmd_s};
        bit_cnt_d = bit_cnt_q + BIT_CNT_BITS'(1);
      end
      ST_PARITY: begin
        par_d = cmd_s;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    frame_done_c = (state_q == ST_STOP);
    stop_ok_c    = ~cmd_s;
    parity_ok_c  = ~(^{shift_q, par_q});
    fields_o     = cmd_fields_t'(shift_q);
  end

endmodule

// File: rtl/anita3_surf_cmd_receiver.sv
// SURF command receiver: registers decoded commands, tracks pending hold
// buffers and counts line errors.
module anita3_surf_cmd_receiver
  import anita3_surf_cmd_receiver_pkg::*;
(
  input  logic                     clk33_i,
  input  logic                     rst_i,
  input  logic                     CMD_i,
  input  logic [NUM_BUFFERS-1:0]   buf_done_i,
  output logic                     cmd_valid_o,
  output logic [TYPE_BITS-1:0]     cmd_type_o,
  output logic [BUF_BITS-1:0]      cmd_buffer_o,
  output logic [NUM_DATA_BITS-1:0] cmd_data_o,
  output logic                     digitize_o,
  output logic [NUM_BUFFERS-1:0]   buffer_pending_o,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     overrun_o,
  output logic [ERR_CNT_BITS-1:0]  err_count_o
);

  logic        frame_done_c, parity_ok_c, stop_ok_c;
  cmd_fields_t fields;
  logic        good_c, perr_c, ferr_c;
  logic [NUM_BUFFERS-1:0] pend_after_done_c;

  logic                     cmd_valid_q, cmd_valid_d;
  logic [TYPE_BITS-1:0]     cmd_type_q, cmd_type_d;
  logic [BUF_BITS-1:0]      cmd_buffer_q, cmd_buffer_d;
  logic [NUM_DATA_BITS-1:0] cmd_data_q, cmd_data_d;
  logic                     digitize_q, digitize_d;
  logic [NUM_BUFFERS-1:0]   pending_q, pending_d;
  logic                     parity_err_q, parity_err_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic [ERR_CNT_BITS-1:0]  err_count_q, err_count_d;

  anita3_surf_cmd_receiver_deser u_deser (
    .clk33_i      (clk33_i),
    .rst_i        (rst_i),
    .cmd_i        (CMD_i),
    .frame_done_c (frame_done_c),
    .parity_ok_c  (parity_ok_c),
    .stop_ok_c    (stop_ok_c),
    .fields_o     (fields)
  );

  // A bad stop bit is a framing error whatever the parity says
  always_comb begin
    good_c = frame_done_c & stop_ok_c & parity_ok_c;
    perr_c = frame_done_c & stop_ok_c & ~parity_ok_c;
    ferr_c = frame_done_c & ~stop_ok_c;
  end

  always_comb begin
    cmd_valid_d  = good_c;
    cmd_type_d   = cmd_type_q;
    cmd_buffer_d = cmd_buffer_q;
    cmd_data_d   = cmd_data_q;
    digitize_d   = 1'b0;
    parity_err_d = perr_c;
    frame_err_d  = ferr_c;
    if (good_c) begin
      cmd_type_d   = fields.cmd_type;
      cmd_buffer_d = fields.buffer;
      cmd_data_d   = fields.data;
      digitize_d   = (fields.cmd_type == CMD_DIGITIZE);
    end
  end

  // Readout-done clears land before the new command, so a coincident
  // re-digitize of the same buffer is not an overrun
  always_comb begin
    pend_after_done_c = pending_q & ~buf_done_i;
    pending_d         = pend_after_done_c;
    overrun_d         = 1'b0;
    if (good_c) begin
      case (fields.cmd_type)
        CMD_DIGITIZE: begin
          overrun_d                = pend_after_done_c[fields.buffer];
          pending_d[fields.buffer] = 1'b1;
        end
        CMD_CLEAR:     pending_d[fields.buffer] = 1'b0;
        CMD_CLEAR_ALL: pending_d = '0;
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (perr_c | ferr_c | overrun_d) err_count_d = sat_inc(err_count_q);
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      cmd_valid_q  <= 1'b0;
      cmd_type_q   <= '0;
      cmd_buffer_q <= '0;
      cmd_data_q   <= '0;
      digitize_q   <= 1'b0;
      pending_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      cmd_valid_q  <= cmd_valid_d;
      cmd_type_q   <= cmd_type_d;
      cmd_buffer_q <= cmd_buffer_d;
      cmd_data_q   <= cmd_data_d;
      digitize_q   <= digitize_d;
      pending_q    <= pending_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      err_count_q  <= err_count_d;
    end
  end

  assign cmd_valid_o      = cmd_valid_q;
  assign cmd_type_o       = cmd_type_q;
  assign cmd_buffer_o     = cmd_buffer_q;
  assign cmd_data_o       = cmd_data_q;
  assign digitize_o       = digitize_q;
  assign buffer_pending_o = pending_q;
  assign parity_err_o     = parity_err_q;
  assign frame_err_o      = frame_err_q;
  assign overrun_o        = overrun_q;
  assign err_count_o      = err_count_q;

endmodule

// File: tb/tb_anita3_surf_cmd_receiver.sv
// Self-checking bench for the SURF command receiver against a frame-level model.
module tb_anita3_surf_cmd_receiver;

  logic        clk33_i = 1'b0;
  logic        rst_i;
  logic        CMD_i;
  logic [3:0]  buf_done_i;
  logic        cmd_valid_o;
  logic [1:0]  cmd_type_o;
  logic [1:0]  cmd_buffer_o;
  logic [31:0] cmd_data_o;
  logic        digitize_o;
  logic [3:0]  buffer_pending_o;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic [7:0]  err_count_o;

  anita3_surf_cmd_receiver dut (
    .clk33_i          (clk33_i),
    .rst_i            (rst_i),
    .CMD_i            (CMD_i),
    .buf_done_i       (buf_done_i),
    .cmd_valid_o      (cmd_valid_o),
    .cmd_type_o       (cmd_type_o),
    .cmd_buffer_o     (cmd_buffer_o),
    .cmd_data_o       (cmd_data_o),
    .digitize_o       (digitize_o),
    .buffer_pending_o (buffer_pending_o),
    .parity_err_o     (parity_err_o),
    .frame_err_o      (frame_err_o),
    .overrun_o        (overrun_o),
    .err_count_o      (err_count_o)
  );

  always #15 clk33_i = ~clk33_i;

  int cyc = 0;
  always @(posedge clk33_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Event log filled from the opposite clock edge
  int          vld_t[$];
  logic [1:0]  vld_type[$];
  logic [1:0]  vld_buf[$];
  logic [31:0] vld_data[$];
  int          dig_t[$];
  int          perr_t[$];
  int          ferr_t[$];
  int          ovr_t[$];

  always @(negedge clk33_i) begin
    if (cmd_valid_o) begin
      vld_t.push_back(cyc);
      vld_type.push_back(cmd_type_o);
      vld_buf.push_back(cmd_buffer_o);
      vld_data.push_back(cmd_data_o);
    end
    if (digitize_o)   dig_t.push_back(cyc);
    if (parity_err_o) perr_t.push_back(cyc);
    if (frame_err_o)  ferr_t.push_back(cyc);
    if (overrun_o)    ovr_t.push_back(cyc);
  end

  task automatic clear_log();
    vld_t.delete(); vld_type.delete(); vld_buf.delete(); vld_data.delete();
    dig_t.delete(); perr_t.delete(); ferr_t.delete(); ovr_t.delete();
  endtask

  // Frame-level reference model
  bit          mdl_pend[4];
  int          mdl_err;
  logic [1:0]  mdl_type;
  logic [1:0]  mdl_buf;
  logic [31:0] mdl_data;

  task automatic model_reset();
    for (int n = 0; n < 4; n++) mdl_pend[n] = 1'b0;
    mdl_err = 0; mdl_type = 2'd0; mdl_buf = 2'd0; mdl_data = 32'd0;
  endtask

  function automatic logic [3:0] mdl_mask();
    logic [3:0] m;
    for (int n = 0; n < 4; n++) m[n] = mdl_pend[n];
    return m;
  endfunction

  task automatic model_frame(input logic [1:0] t, input logic [1:0] b, input logic [31:0] d,
                             input bit bad_par, input bit bad_stop, input logic [3:0] done,
                             output bit e_vld, output bit e_perr, output bit e_ferr, output bit e_ovr);
    for (int n = 0; n < 4; n++) if (done[n]) mdl_pend[n] = 1'b0;
    e_ferr = bad_stop;
    e_perr = !bad_stop && bad_par;
    e_vld  = !bad_stop && !bad_par;
    e_ovr  = 1'b0;
    if (e_vld) begin
      mdl_type = t; mdl_buf = b; mdl_data = d;
      if (t == 2'd0) begin
        e_ovr = mdl_pend[b];
        mdl_pend[b] = 1'b1;
      end else if (t == 2'd1) begin
        mdl_pend[b] = 1'b0;
      end else if (t == 2'd3) begin
        for (int n = 0; n < 4; n++) mdl_pend[n] = 1'b0;
      end
    end
    if ((e_perr || e_ferr || e_ovr) && mdl_err < 255) mdl_err++;
  endtask

  function automatic logic [38:0] build_frame(input logic [1:0] t, input logic [1:0] b,
                                              input logic [31:0] d, input bit bad_par, input bit bad_stop);
    logic [38:0] fb;
    logic p;
    fb = '0;
    fb[0] = 1'b1;
    fb[1] = t[1]; fb[2] = t[0];
    fb[3] = b[1]; fb[4] = b[0];
    for (int i = 0; i < 32; i++) fb[5+i] = d[31-i];
    p = 1'b0;
    for (int i = 1; i <= 36; i++) p = p ^ fb[i];
    fb[37] = p ^ bad_par;
    fb[38] = bad_stop;
    return fb;
  endfunction

  task automatic send_frame(input logic [1:0] t, input logic [1:0] b, input logic [31:0] d,
                            input bit bad_par, input bit bad_stop, input int idle_n,
                            input bit idle_lvl, input logic [3:0] done, output int stop_cyc);
    logic [38:0] fb;
    fb = build_frame(t, b, d, bad_par, bad_stop);
    stop_cyc = 0;
    for (int i = 0; i < 39; i++) begin
      CMD_i = fb[i];
      if (i == 38) stop_cyc = cyc;
      @(posedge clk33_i); #1;
    end
    for (int k = 0; k < idle_n; k++) begin
      CMD_i = idle_lvl;
      buf_done_i = (k == 1) ? done : 4'b0000;
      @(posedge clk33_i); #1;
    end
    buf_done_i = 4'b0000;
  endtask

  task automatic idle(input int n);
    CMD_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk33_i); #1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; CMD_i = 1'b0; buf_done_i = 4'b0000;
    repeat (3) @(posedge clk33_i);
    #1;
    n_checks++;
    if ({cmd_valid_o, cmd_type_o, cmd_buffer_o, cmd_data_o, digitize_o, buffer_pending_o,
         parity_err_o, frame_err_o, overrun_o, err_count_o} !== 55'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h pend=%b err=%0d, required all zero",
               cmd_data_o, buffer_pending_o, err_count_o);
    end
    rst_i = 1'b0;
    model_reset();
    idle(5);
    n_checks++;
    if ({cmd_valid_o, parity_err_o, frame_err_o, err_count_o} !== 11'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: valid=%b perr=%b ferr=%b err=%0d, required zero",
               cmd_valid_o, parity_err_o, frame_err_o, err_count_o);
    end
  endtask

  task automatic test_digitize();
    bit ev, ep, ef, eo; int s; int gt;
    clear_log();
    model_frame(2'd0, 2'd2, 32'h12345678, 0, 0, 4'b0, ev, ep, ef, eo);
    send_frame(2'd0, 2'd2, 32'h12345678, 0, 0, 4, 1'b0, 4'b0, s);
    gt = (vld_t.size() == 1) ? vld_t[0] : -1;
    n_checks++;
    if (gt !== s + 3) begin n_fail++; $display("FAIL dig_valid_time: got %0d, required %0d", gt, s + 3); end
    gt = (dig_t.size() == 1) ? dig_t[0] : -1;
    n_checks++;
    if (gt !== s + 3) begin n_fail++; $display("FAIL dig_pulse_time: got %0d, required %0d", gt, s + 3); end
    n_checks++;
    if (cmd_data_o !== 32'h12345678) begin n_fail++; $display("FAIL dig_data: got %h, required 12345678", cmd_data_o); end
    n_checks++;
    if ({cmd_type_o, cmd_buffer_o} !== 4'b0010) begin
      n_fail++; $display("FAIL dig_fields: got type=%0d buf=%0d, required type=0 buf=2", cmd_type_o, cmd_buffer_o);
    end
    n_checks++;
    if (buffer_pending_o !== 4'b0100) begin n_fail++; $display("FAIL dig_pending: got %b, required 0100", buffer_pending_o); end
  endtask

  task automatic test_parity();
    bit ev, ep, ef, eo; int s; int gt;
    clear_log();
    model_frame(2'd0, 2'd2, 32'h12345678, 1, 0, 4'b0, ev, ep, ef, eo);
    send_frame(2'd0, 2'd2, 32'h12345678, 1, 0, 4, 1'b0, 4'b0, s);
    gt = (perr_t.size() == 1) ? perr_t[0] : -1;
    n_checks++;
    if (gt !== s + 3) begin n_fail++; $display("FAIL par_err_time: got %0d, required %0d", gt, s + 3); end
    n_checks++;
    if (vld_t.size() + ferr_t.size() + ovr_t.size() !== 0) begin
      n_fail++; $display("FAIL par_no_valid: got %0d other events, required 0", vld_t.size() + ferr_t.size() + ovr_t.size());
    end
    n_checks++;
    if (buffer_pending_o !== 4'b0100) begin n_fail++; $display("FAIL par_pending: got %b, required 0100", buffer_pending_o); end
    n_checks++;
    if (err_count_o !== 8'd1) begin n_fail++; $display("FAIL par_err_count: got %0d, required 1", err_count_o); end
  endtask

  task automatic test_frame_err();
    bit ev, ep, ef, eo; int s1, s2; int gt;
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    clear_log();
    model_frame(2'd0, 2'd0, d1, 0, 1, 4'b0, ev, ep, ef, eo);
    send_frame(2'd0, 2'd0, d1, 0, 1, 10, 1'b1, 4'b0, s1);
    n_checks++;
    if (vld_t.size() !== 0) begin n_fail++; $display("FAIL ferr_no_decode_high: got %0d valids, required 0", vld_t.size()); end
    idle(3);
    model_frame(2'd0, 2'd0, d2, 0, 0, 4'b0, ev, ep, ef, eo);
    send_frame(2'd0, 2'd0, d2, 0, 0, 4, 1'b0, 4'b0, s2);
    gt = (ferr_t.size() == 1) ? ferr_t[0] : -1;
    n_checks++;
    if (gt !== s1 + 3) begin n_fail++; $display("FAIL ferr_time: got %0d, required %0d", gt, s1 + 3); end
    n_checks++;
    if (perr_t.size() !== 0) begin n_fail++; $display("FAIL ferr_no_perr: got %0d, required 0", perr_t.size()); end
    gt = (vld_t.size() == 1) ? vld_t[0] : -1;
    n_checks++;
    if (gt !== s2 + 3) begin n_fail++; $display("FAIL ferr_recover_time: got %0d, required %0d", gt, s2 + 3); end
    n_checks++;
    if (cmd_data_o !== d2) begin n_fail++; $display("FAIL ferr_recover_data: got %h, required %h", cmd_data_o, d2); end
    n_checks++;
    if (buffer_pending_o !== mdl_mask() || err_count_o !== 8'(mdl_err)) begin
      n_fail++; $display("FAIL ferr_state: got pend=%b err=%0d, required pend=%b err=%0d",
                         buffer_pending_o, err_count_o, mdl_mask(), mdl_err);
    end
  endtask

  task automatic test_overrun();
    bit ev, ep, ef, eo; int s; logic [3:0] done; logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      done = (i == 2) ? 4'b0010 : 4'b0000;
      d = $urandom;
      clear_log();
      model_frame(2'd0, 2'd1, d, 0, 0, done, ev, ep, ef, eo);
      send_frame(2'd0, 2'd1, d, 0, 0, 4, 1'b0, done, s);
      n_checks++;
      if (ovr_t.size() !== ((i == 1) ? 1 : 0)) begin
        n_fail++; $display("FAIL ovr_frame%0d: got %0d overruns, required %0d", i, ovr_t.size(), (i == 1) ? 1 : 0);
      end
      n_checks++;
      if (buffer_pending_o[1] !== 1'b1 || err_count_o !== 8'(mdl_err)) begin
        n_fail++; $display("FAIL ovr_state%0d: got pend=%b err=%0d, required bit1 set err=%0d",
                           i, buffer_pending_o, err_count_o, mdl_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ev, ep, ef, eo; int sa, sb, sc; int gap; logic [31:0] da, db; logic [1:0] bb;
    da = $urandom; db = $urandom; bb = 2'($urandom_range(0, 3));
    clear_log();
    model_frame(2'd0, 2'd3, da, 0, 0, 4'b0, ev, ep, ef, eo);
    send_frame(2'd0, 2'd3, da, 0, 0, 0, 1'b0, 4'b0, sa);
    model_frame(2'd2, bb, db, 0, 0, 4'b0, ev, ep, ef, eo);
    send_frame(2'd2, bb, db, 0, 0, 4, 1'b0, 4'b0, sb);
    n_checks++;
    if (vld_t.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d valids, required 2", vld_t.size()); end
    gap = (vld_t.size() == 2) ? vld_t[1] - vld_t[0] : -1;
    n_checks++;
    if (gap !== 39 || vld_t.size() != 2 || vld_t[0] !== sa + 3) begin
      n_fail++; $display("FAIL b2b_spacing: got gap %0d, required 39 starting at %0d", gap, sa + 3);
    end
    n_checks++;
    if (vld_type.size() != 2 || vld_type[1] !== 2'd2 || vld_data[1] !== db || vld_data[0] !== da) begin
      n_fail++; $display("FAIL b2b_fields: got %0d records, required rsvd frame data %h after %h", vld_type.size(), db, da);
    end
    n_checks++;
    if (buffer_pending_o !== mdl_mask()) begin
      n_fail++; $display("FAIL b2b_rsvd_pending: got %b, required %b", buffer_pending_o, mdl_mask());
    end
    model_frame(2'd3, 2'd0, 32'h0, 0, 0, 4'b0, ev, ep, ef, eo);
    send_frame(2'd3, 2'd0, 32'h0, 0, 0, 4, 1'b0, 4'b0, sc);
    n_checks++;
    if (buffer_pending_o !== 4'b0000) begin n_fail++; $display("FAIL clear_all: got %b, required 0000", buffer_pending_o); end
  endtask

  task automatic test_reset_midframe();
    bit ev, ep, ef, eo; int s; logic [38:0] fb; logic [31:0] d;
    model_frame(2'd0, 2'd3, 32'hCAFEF00D, 0, 0, 4'b0, ev, ep, ef, eo);
    send_frame(2'd0, 2'd3, 32'hCAFEF00D, 0, 0, 4, 1'b0, 4'b0, s);
    // Remnant after release is all zeros, so it cannot look like a start bit
    fb = build_frame(2'd0, 2'd0, 32'h5A5A0000, 0, 0);
    clear_log();
    for (int i = 0; i < 39; i++) begin
      CMD_i = fb[i];
      if (i == 20) rst_i = 1'b1;
      if (i == 23) rst_i = 1'b0;
      if (i == 22) begin
        n_checks++;
        if ({cmd_valid_o, cmd_type_o, cmd_buffer_o, cmd_data_o, digitize_o, buffer_pending_o,
             parity_err_o, frame_err_o, overrun_o, err_count_o} !== 55'd0) begin
          n_fail++; $display("FAIL midreset_outputs: got data=%h pend=%b err=%0d, required all zero",
                             cmd_data_o, buffer_pending_o, err_count_o);
        end
      end
      @(posedge clk33_i); #1;
    end
    model_reset();
    idle(8);
    n_checks++;
    if (vld_t.size() + perr_t.size() + ferr_t.size() + ovr_t.size() !== 0) begin
      n_fail++; $display("FAIL midreset_remnant: got %0d events, required 0",
                         vld_t.size() + perr_t.size() + ferr_t.size() + ovr_t.size());
    end
    d = $urandom;
    clear_log();
    model_frame(2'd0, 2'd1, d, 0, 0, 4'b0, ev, ep, ef, eo);
    send_frame(2'd0, 2'd1, d, 0, 0, 4, 1'b0, 4'b0, s);
    n_checks++;
    if (vld_t.size() !== 1 || cmd_data_o !== d || buffer_pending_o !== 4'b0010 || err_count_o !== 8'd0) begin
      n_fail++; $display("FAIL midreset_recover: got %0d valids data=%h pend=%b err=%0d, required 1 valid data=%h pend=0010 err=0",
                         vld_t.size(), cmd_data_o, buffer_pending_o, err_count_o, d);
    end
  endtask

  task automatic test_random();
    bit ev, ep, ef, eo; int s; int gt;
    logic [1:0] t, b; logic [31:0] d; bit bp, bs; logic [3:0] done;
    for (int i = 0; i < 40; i++) begin
      t = 2'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3)); d = $urandom;
      bp = ($urandom_range(0, 7) == 0); bs = ($urandom_range(0, 9) == 0);
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      clear_log();
      model_frame(t, b, d, bp, bs, done, ev, ep, ef, eo);
      send_frame(t, b, d, bp, bs, 3, 1'b0, done, s);
      gt = (vld_t.size() == 1) ? vld_t[0] : -1;
      n_checks++;
      if (vld_t.size() !== int'(ev) || (ev && gt !== s + 3)) begin
        n_fail++; $display("FAIL rnd%0d_valid: got %0d valids at %0d, required %0d at %0d", i, vld_t.size(), gt, ev, s + 3);
      end
      n_checks++;
      if ({cmd_type_o, cmd_buffer_o, cmd_data_o} !== {mdl_type, mdl_buf, mdl_data}) begin
        n_fail++; $display("FAIL rnd%0d_fields: got %0d/%0d/%h, required %0d/%0d/%h",
                           i, cmd_type_o, cmd_buffer_o, cmd_data_o, mdl_type, mdl_buf, mdl_data);
      end
      n_checks++;
      if (dig_t.size() !== int'(ev && t == 2'd0) || perr_t.size() !== int'(ep) ||
          ferr_t.size() !== int'(ef) || ovr_t.size() !== int'(eo)) begin
        n_fail++; $display("FAIL rnd%0d_pulses: got dig=%0d perr=%0d ferr=%0d ovr=%0d, required %0d/%0d/%0d/%0d",
                           i, dig_t.size(), perr_t.size(), ferr_t.size(), ovr_t.size(), ev && t == 2'd0, ep, ef, eo);
      end
      n_checks++;
      if (buffer_pending_o !== mdl_mask() || err_count_o !== 8'(mdl_err)) begin
        n_fail++; $display("FAIL rnd%0d_state: got pend=%b err=%0d, required pend=%b err=%0d",
                           i, buffer_pending_o, err_count_o, mdl_mask(), mdl_err);
      end
    end
  endtask

  task automatic test_saturation();
    bit ev, ep, ef, eo; int s;
    clear_log();
    for (int i = 0; i < 256; i++) begin
      model_frame(2'd1, 2'd0, 32'h0000FFFF, 1, 0, 4'b0, ev, ep, ef, eo);
      send_frame(2'd1, 2'd0, 32'h0000FFFF, 1, 0, 3, 1'b0, 4'b0, s);
    end
    n_checks++;
    if (err_count_o !== 8'(mdl_err) || err_count_o !== 8'd255) begin
      n_fail++; $display("FAIL err_saturate: got %0d, required 255", err_count_o);
    end
    n_checks++;
    if (vld_t.size() !== 0 || perr_t.size() !== 256) begin
      n_fail++; $display("FAIL sat_pulses: got %0d valids %0d perr, required 0 and 256", vld_t.size(), perr_t.size());
    end
  endtask

  initial begin
    #(30 * 60000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_digitize();
    test_parity();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
